// File: rtl/axi_read_arbiter_pkg.sv
// axi_read_arbiter_pkg
// Shared types and constants for the AXI read-channel arbiter and its
// round-robin helper.
//   axi_arb_state_t : arbiter FSM states (IDLE / ADDR / DATA)
//   axi_ar_t        : registered AR payload (addr, len, size, burst)
//   AXI_BURST_INCR  : AXI INCR burst encoding
//   idx_width()     : width of a binary index over n requesters (min 1)
package axi_read_arbiter_pkg;

    localparam int         AXI_ADDR_WIDTH = 32;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } axi_arb_state_t;

    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
    } axi_ar_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at the index
// after last_grant_i and wraps modulo NUM_REQ, so the most recent winner has
// the lowest priority.
//   req_i        : request vector
//   last_grant_i : index of the previous winner
//   grant_oh_o   : one-hot grant (all zero when nothing requests)
//   grant_idx_o  : binary grant index (0 when nothing requests)
//   valid_o      : at least one request present
module rr_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDXW   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDXW-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output logic [IDXW-1:0]    grant_idx_o,
    output logic               valid_o
);

    logic [IDXW-1:0] cand;
    logic            found;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDXW'((int'(last_grant_i) + off) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found             = 1'b1;
                grant_oh_o[cand]  = 1'b1;
                grant_idx_o       = cand;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
// Shares one AXI4 read channel between NUM_REQ masters (0 = I-bus,
// 1 = D-bus), one burst outstanding, round-robin per burst. The grant is
// held from AR acceptance until the RLAST handshake.
// Ports:
//   clk, rst                  : clock, synchronous active-low reset
//   s_ar*                     : per-requester AR channels (packed by index)
//   s_r*                      : R channel routed to the granted requester
//   m_ar*, m_r*               : memory-side AXI read channel
//   grant_idx                 : current / last granted requester
//   busy                      : FSM not idle
//   burst_err                 : sticky beat-count vs. rlast mismatch
//   dbg_state                 : FSM state for observation
// Handshake rule used throughout: a transfer happens on a rising edge where
// valid and ready are both high; valid never waits on ready.
// ADDR_WIDTH must equal AXI_ADDR_WIDTH of the package (payload struct width).
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    localparam int IDXW      = idx_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            s_arvalid,
    output logic [NUM_REQ-1:0]            s_arready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_REQ*8-1:0]          s_arlen,
    input  logic [NUM_REQ*3-1:0]          s_arsize,
    input  logic [NUM_REQ*2-1:0]          s_arburst,
    output logic [NUM_REQ-1:0]            s_rvalid,
    input  logic [NUM_REQ-1:0]            s_rready,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic [IDXW-1:0]               grant_idx,
    output logic                          busy,
    output logic                          burst_err,
    output axi_arb_state_t                dbg_state
);

    axi_arb_state_t  state_q, state_d;
    axi_ar_t         ar_q, ar_sel;
    logic            m_arvalid_q;
    logic [IDXW-1:0] grant_q;
    logic [IDXW-1:0] last_grant_q;
    logic [7:0]      beat_q;
    logic            burst_err_q;

    logic [NUM_REQ-1:0] arb_oh;
    logic [IDXW-1:0]    arb_idx;
    logic               arb_valid;
    logic               r_hs;
    logic               beat_mismatch;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i        (s_arvalid),
        .last_grant_i (last_grant_q),
        .grant_oh_o   (arb_oh),
        .grant_idx_o  (arb_idx),
        .valid_o      (arb_valid)
    );

    // Payload of the current arbitration winner.
    always_comb begin
        ar_sel.addr  = s_araddr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
        ar_sel.len   = s_arlen[arb_idx*8 +: 8];
        ar_sel.size  = s_arsize[arb_idx*3 +: 3];
        ar_sel.burst = s_arburst[arb_idx*2 +: 2];
    end

    // Error on rlast at the wrong beat, or a missing rlast on the final beat.
    assign beat_mismatch = m_rlast ? (beat_q != ar_q.len) : (beat_q == ar_q.len);

    // State register plus the datapath registers it controls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            ar_q         <= '0;
            m_arvalid_q  <= 1'b0;
            grant_q      <= '0;
            last_grant_q <= IDXW'(NUM_REQ - 1);
            beat_q       <= '0;
            burst_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        ar_q        <= ar_sel;
                        grant_q     <= arb_idx;
                        m_arvalid_q <= 1'b1;
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        m_arvalid_q <= 1'b0;
                        beat_q      <= '0;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_q <= beat_q + 8'd1;
                        if (beat_mismatch) burst_err_q <= 1'b1;
                        if (m_rlast) last_grant_q <= grant_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic. m_arvalid is always high in ADDR, so m_arready alone
    // completes the AR handshake there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = ADDR;
            ADDR:    if (m_arready) state_d = DATA;
            DATA:    if (r_hs && m_rlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: AR accept pulse in IDLE, R routing in DATA.
    always_comb begin
        s_arready = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        r_hs      = 1'b0;
        case (state_q)
            IDLE: s_arready = arb_oh;
            DATA: begin
                m_rready          = s_rready[grant_q];
                s_rvalid[grant_q] = m_rvalid;
                r_hs              = m_rvalid && s_rready[grant_q];
            end
            default: ;
        endcase
    end

    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;
    assign m_araddr  = ar_q.addr;
    assign m_arlen   = ar_q.len;
    assign m_arsize  = ar_q.size;
    assign m_arburst = ar_q.burst;
    assign m_arvalid = m_arvalid_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q != IDLE);
    assign burst_err = burst_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;
  import axi_read_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NUM_REQ*AW-1:0] s_araddr;
  logic [NUM_REQ*8-1:0]  s_arlen;
  logic [NUM_REQ*3-1:0]  s_arsize;
  logic [NUM_REQ*2-1:0]  s_arburst;
  logic [DW-1:0]         s_rdata, m_rdata;
  logic [1:0]            s_rresp, m_rresp;
  logic                  s_rlast, m_rlast, m_rvalid, m_rready;
  logic [AW-1:0]         m_araddr;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;
  logic                  m_arvalid, m_arready;
  logic [0:0]            grant_idx;
  logic                  busy, burst_err;
  axi_arb_state_t        dbg_state;

  axi_read_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant_idx(grant_idx), .busy(busy), .burst_err(burst_err),
    .dbg_state(dbg_state)
  );

  // ---------------- stimulus data ----------------
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nb;   // beats the memory sends; rlast on beat nb-1
  } req_t;

  req_t req_q[NUM_REQ][$];

  int rready_pct = 100;
  int arready_pct = 100;
  int rvalid_pct = 100;
  int arready_block = 0;
  logic [NUM_REQ-1:0] rready_low = '0;

  // memory responder state
  req_t mem_act;
  bit   mem_act_valid = 1'b0;
  int   mem_beat = 0;

  // reference model state (transaction level)
  int   m_phase = 0;          // 0 idle, 1 address, 2 data
  int   m_last = NUM_REQ - 1;
  int   m_grant = 0;
  bit   m_err = 1'b0;
  int   m_beat = 0;
  req_t cur_req;
  int   acc_log[$];
  bit   run = 1'b0;

  // scoreboard: {idx, last, resp, data}
  logic [35:0] exp_q[$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_fn(input logic [31:0] a, input int b);
    return a ^ (32'(b) * 32'h0101_0101) ^ 32'h5A00_0000;
  endfunction

  function automatic logic [1:0] resp_fn(input logic [31:0] a, input int b);
    return 2'(b) ^ a[3:2];
  endfunction

  // mode 0: normal, 1: rlast early after k beats, 2: one extra beat
  task automatic push_req(input int i, input logic [31:0] addr, input int len, input int mode, input int k);
    req_t r;
    r.addr  = addr;
    r.len   = 8'(len);
    r.size  = 3'($urandom_range(0, 2));
    r.burst = AXI_BURST_INCR;
    if (mode == 1 && len > 0) r.nb = k;
    else if (mode == 2) r.nb = len + 2;
    else r.nb = len + 1;
    req_q[i].push_back(r);
  endtask

  // ---------------- drivers (requesters + memory) ----------------
  initial begin
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_rready = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    m_rresp = '0; m_rlast = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rst && req_q[i].size() > 0) begin
          s_arvalid[i] = 1'b1;
          s_araddr[i*AW +: AW] = req_q[i][0].addr;
          s_arlen[i*8 +: 8]    = req_q[i][0].len;
          s_arsize[i*3 +: 3]   = req_q[i][0].size;
          s_arburst[i*2 +: 2]  = req_q[i][0].burst;
        end else begin
          s_arvalid[i] = 1'b0;
          s_araddr[i*AW +: AW] = $urandom;
          s_arlen[i*8 +: 8]    = 8'($urandom);
          s_arsize[i*3 +: 3]   = 3'($urandom);
          s_arburst[i*2 +: 2]  = 2'($urandom);
        end
        s_rready[i] = !rready_low[i] && ($urandom_range(0, 99) < rready_pct);
      end
      if (arready_block > 0) begin
        m_arready = 1'b0;
        arready_block--;
      end else begin
        m_arready = ($urandom_range(0, 99) < arready_pct);
      end
      if (rst && mem_act_valid) begin
        m_rvalid = ($urandom_range(0, 99) < rvalid_pct);
        m_rdata  = data_fn(mem_act.addr, mem_beat);
        m_rresp  = resp_fn(mem_act.addr, mem_beat);
        m_rlast  = (mem_beat == mem_act.nb - 1);
      end else begin
        m_rvalid = 1'b0;
        m_rdata  = $urandom;
        m_rresp  = 2'($urandom);
        m_rlast  = 1'($urandom);
      end
    end
  end

  // ---------------- monitor: reference model + scoreboard ----------------
  logic [NUM_REQ-1:0] e_arready, e_rvalid;
  axi_arb_state_t     e_state;
  int                 win;
  int                 cidx;
  logic [35:0]        e_beat;
  bit                 hs;

  always @(negedge clk) begin
    if (run) begin
      if (!rst) begin
        m_phase = 0; m_last = NUM_REQ - 1; m_grant = 0; m_err = 1'b0; m_beat = 0;
        exp_q.delete();
        mem_act_valid = 1'b0;
      end else begin
        win = -1;
        for (int off = 1; off <= NUM_REQ; off++) begin
          cidx = (m_last + off) % NUM_REQ;
          if (win < 0 && s_arvalid[cidx]) win = cidx;
        end
        e_arready = '0;
        if (m_phase == 0 && win >= 0) e_arready = NUM_REQ'(1) << win;
        e_rvalid = '0;
        if (m_phase == 2 && m_rvalid) e_rvalid = NUM_REQ'(1) << m_grant;
        e_state = (m_phase == 0) ? IDLE : (m_phase == 1) ? ADDR : DATA;

        check("s_arready", s_arready, e_arready);
        check("m_arvalid", m_arvalid, m_phase == 1);
        check("busy", busy, m_phase != 0);
        check("state", dbg_state, e_state);
        check("grant_idx", grant_idx, m_grant);
        check("burst_err", burst_err, m_err);
        check("s_rvalid", s_rvalid, e_rvalid);
        check("m_rready", m_rready, m_phase == 2 && s_rready[m_grant]);
        if (m_phase == 1)
          check("m_ar_payload", {m_araddr, m_arlen, m_arsize, m_arburst},
                {cur_req.addr, cur_req.len, cur_req.size, cur_req.burst});

        // scoreboard side: pop whenever the DUT delivers a routed beat
        for (int i = 0; i < NUM_REQ; i++) begin
          if (s_rvalid[i] && s_rready[i]) begin
            if (exp_q.size() == 0) begin
              check("r_unexpected_beat", 1, 0);
            end else begin
              e_beat = exp_q.pop_front();
              check("r_beat", {1'(i), s_rlast, s_rresp, s_rdata}, e_beat);
            end
          end
        end

        // model advance
        case (m_phase)
          0: if (win >= 0) begin
            cur_req = req_q[win].pop_front();
            for (int b = 0; b < cur_req.nb; b++)
              exp_q.push_back({1'(win), 1'(b == cur_req.nb - 1),
                               resp_fn(cur_req.addr, b), data_fn(cur_req.addr, b)});
            m_grant = win;
            acc_log.push_back(win);
            m_phase = 1;
          end
          1: if (m_arready) begin
            m_phase = 2;
            m_beat = 0;
            mem_act = cur_req;
            mem_beat = 0;
            mem_act_valid = 1'b1;
          end
          default: begin
            hs = m_rvalid && s_rready[m_grant];
            if (hs) begin
              if ((m_rlast && m_beat != int'(cur_req.len)) ||
                  (!m_rlast && m_beat == int'(cur_req.len))) m_err = 1'b1;
              m_beat++;
              mem_beat++;
              if (m_rlast) begin
                m_phase = 0;
                m_last = m_grant;
                mem_act_valid = 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

  // ---------------- sequencer helpers ----------------
  task automatic wait_idle(input string name);
    int cnt = 0;
    while (!(req_q[0].size() == 0 && req_q[1].size() == 0 && m_phase == 0 &&
             exp_q.size() == 0) && cnt < 3000) begin
      @(posedge clk);
      cnt++;
    end
    if (cnt >= 3000) check({"timeout_", name}, 1, 0);
  endtask

  task automatic wait_beat(input int target, input string name);
    int cnt = 0;
    while (!(m_phase == 2 && m_beat >= target) && cnt < 1000) begin
      @(posedge clk);
      cnt++;
    end
    if (cnt >= 1000) check({"timeout_", name}, 1, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2; rst = 1'b0;
    @(posedge clk); #2; rst = 1'b1;
  endtask

  int exp_order[4];

  initial begin
    exp_order = '{0, 1, 0, 1};
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_m_arvalid", m_arvalid, 0);
    check("rst_grant_idx", grant_idx, 0);
    check("rst_burst_err", burst_err, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_s_arready", s_arready, 0);
    check("rst_s_rvalid", s_rvalid, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    run = 1'b1;

    // single I-bus burst
    push_req(0, 32'h0000_1000, 3, 0, 0);
    wait_idle("single_ibus");
    @(negedge clk);
    check("t1_burst_err", burst_err, 0);
    check("t1_busy", busy, 0);

    // simultaneous requests after reset, then a third round
    do_reset();
    acc_log.delete();
    @(posedge clk); #2;
    push_req(0, 32'h0000_2000, 1, 0, 0);
    push_req(1, 32'h8000_0040, 2, 0, 0);
    wait_idle("simul_r1");
    #2;
    push_req(0, 32'h0000_3000, 0, 0, 0);
    push_req(1, 32'h8000_0080, 1, 0, 0);
    wait_idle("simul_r2");
    check("order_len", acc_log.size(), 4);
    for (int k = 0; k < 4 && k < acc_log.size(); k++)
      check("order", acc_log[k], exp_order[k]);

    // backpressure on AR and on D-bus R
    #2;
    arready_block = 7;
    push_req(1, 32'h8000_1000, 5, 0, 0);
    wait_beat(1, "bp_beat");
    rready_low[1] = 1'b1;
    repeat (3) @(posedge clk);
    rready_low[1] = 1'b0;
    wait_idle("backpressure");

    // rlast early: arlen=3, rlast on beat 2
    #2;
    push_req(0, 32'h0000_4000, 3, 1, 2);
    wait_idle("early_rlast");
    @(negedge clk);
    check("early_err", burst_err, 1);
    check("early_state", dbg_state, IDLE);
    do_reset();
    @(negedge clk);
    check("err_cleared", burst_err, 0);

    // missing rlast on beat 4: stays in DATA until rlast
    @(posedge clk); #2;
    push_req(0, 32'h0000_5000, 3, 2, 0);
    wait_idle("late_rlast");
    @(negedge clk);
    check("late_err", burst_err, 1);

    // reset in the middle of DATA
    @(posedge clk); #2;
    push_req(1, 32'h8000_2000, 7, 0, 0);
    wait_beat(1, "mid_beat");
    do_reset();
    @(negedge clk);
    check("mid_state", dbg_state, IDLE);
    check("mid_m_arvalid", m_arvalid, 0);
    check("mid_s_rvalid", s_rvalid, 0);
    check("mid_grant_idx", grant_idx, 0);
    check("mid_burst_err", burst_err, 0);

    // single-beat burst
    @(posedge clk); #2;
    push_req(1, 32'h8000_3000, 0, 0, 0);
    wait_idle("single_beat");
    @(negedge clk);
    check("single_err", burst_err, 0);
    check("single_busy", busy, 0);

    // randomized traffic
    rready_pct = 70; arready_pct = 60; rvalid_pct = 70;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 99) < 20) begin
        int md;
        int ln;
        md = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
        ln = $urandom_range(0, 7);
        push_req($urandom_range(0, 1), $urandom & 32'hFFFF_FFF0, ln, md,
                 (ln > 0) ? int'($urandom_range(1, ln)) : 1);
      end
    end
    wait_idle("random");
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
